// File: rtl/window_streamer.sv
// Raster-order pixel stream to K x K window producer (K = 3 or 5, stride 1, no padding).
// Trailing rows live in circular line buffers; windows leave through a registered valid/ready port.
module window_streamer #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned MAX_W  = 32,
    parameter int unsigned K_MAX  = 5
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start_i,
    input  logic [5:0]                        img_w_i,
    input  logic [5:0]                        img_h_i,
    input  logic [15:0]                       ksize_i,
    input  logic                              in_valid_i,
    output logic                              in_ready_o,
    input  logic [DATA_W-1:0]                 in_pixel_i,
    output logic                              win_valid_o,
    input  logic                              win_ready_i,
    output logic [K_MAX*K_MAX*DATA_W-1:0]     win_data_o,
    output logic [5:0]                        win_row_o,
    output logic [5:0]                        win_col_o,
    output logic                              busy_o,
    output logic                              done_o,
    output logic                              cfg_err_o
);

    localparam int unsigned CW  = $clog2(MAX_W);
    localparam int unsigned NB  = K_MAX - 1;
    localparam int unsigned PW  = $clog2(NB);
    localparam int unsigned WW  = K_MAX * K_MAX * DATA_W;
    localparam int unsigned OFF = K_MAX - 3;

    typedef enum logic [1:0] {StIdle, StLoad, StDrain, StDone} state_e;

    state_e                                 state_q, state_d;
    logic [5:0]                             w_q, w_d, h_q, h_d, k_q, k_d;
    logic [5:0]                             r_q, r_d, c_q, c_d;
    logic [PW-1:0]                          ptr_q, ptr_d;
    logic [K_MAX-1:0][K_MAX-1:0][DATA_W-1:0] sr_q, sr_d;
    logic                                   win_valid_q, win_valid_d;
    logic [WW-1:0]                          win_data_q, win_data_d;
    logic [5:0]                             row_q, row_d, col_q, col_d;
    logic                                   cfg_err_q, cfg_err_d;

    logic [DATA_W-1:0]                      lb_q [NB][MAX_W];
    logic [K_MAX-1:0][DATA_W-1:0]           newcol;
    logic [WW-1:0]                          win_asm;
    logic                                   cfg_ok, accept, last_col, last_pix, emit;

    assign cfg_ok = (ksize_i == 16'd3 || ksize_i == 16'd5) &&
                    (img_w_i >= ksize_i[5:0]) && (img_w_i <= 6'(MAX_W)) &&
                    (img_h_i >= ksize_i[5:0]);

    assign in_ready_o = (state_q == StLoad) && (!win_valid_q || win_ready_i);
    assign accept     = in_valid_i && in_ready_o;
    assign last_col   = (c_q == w_q - 6'd1);
    assign last_pix   = last_col && (r_q == h_q - 6'd1);
    assign emit       = accept && (r_q >= k_q - 6'd1) && (c_q >= k_q - 6'd1);

    // Bank (ptr - m) holds row r-m; bank ptr itself still holds row r-4 until this write.
    assign newcol[K_MAX-1] = in_pixel_i;
    for (genvar m = 1; m <= NB; m++) begin : g_col
        assign newcol[K_MAX-1-m] = lb_q[ptr_q - PW'(m)][c_q[CW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lb_q[ptr_q][c_q[CW-1:0]] <= in_pixel_i;
        end
    end

    always_comb begin
        sr_d = sr_q;
        if (accept) begin
            for (int i = 0; i < K_MAX; i++) begin
                for (int j = 0; j < K_MAX - 1; j++) begin
                    sr_d[i][j] = sr_q[i][j+1];
                end
                sr_d[i][K_MAX-1] = newcol[i];
            end
        end
    end

    // The shift register is always K_MAX square with the newest pixel bottom-right;
    // a 3x3 window is its bottom-right corner.
    for (genvar gi = 0; gi < K_MAX; gi++) begin : g_row
        for (genvar gj = 0; gj < K_MAX; gj++) begin : g_el
            if (gi < 3 && gj < 3) begin : g_in
                assign win_asm[(gi*K_MAX+gj)*DATA_W +: DATA_W] =
                    (k_q == 6'd3) ? sr_d[gi+OFF][gj+OFF] : sr_d[gi][gj];
            end else begin : g_out
                assign win_asm[(gi*K_MAX+gj)*DATA_W +: DATA_W] =
                    (k_q == 6'd3) ? {DATA_W{1'b0}} : sr_d[gi][gj];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        w_d         = w_q;
        h_d         = h_q;
        k_d         = k_q;
        r_d         = r_q;
        c_d         = c_q;
        ptr_d       = ptr_q;
        win_valid_d = win_valid_q && !win_ready_i;
        win_data_d  = win_data_q;
        row_d       = row_q;
        col_d       = col_q;
        cfg_err_d   = 1'b0;
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    if (cfg_ok) begin
                        w_d     = img_w_i;
                        h_d     = img_h_i;
                        k_d     = ksize_i[5:0];
                        r_d     = '0;
                        c_d     = '0;
                        ptr_d   = '0;
                        state_d = StLoad;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            StLoad: begin
                if (accept) begin
                    if (last_col) begin
                        c_d   = '0;
                        r_d   = r_q + 6'd1;
                        ptr_d = (ptr_q == PW'(NB - 1)) ? '0 : ptr_q + PW'(1);
                    end else begin
                        c_d = c_q + 6'd1;
                    end
                    if (last_pix) begin
                        state_d = StDrain;
                    end
                end
                if (emit) begin
                    win_valid_d = 1'b1;
                    win_data_d  = win_asm;
                    row_d       = r_q - k_q + 6'd1;
                    col_d       = c_q - k_q + 6'd1;
                end
            end
            StDrain: begin
                if (win_valid_q && win_ready_i) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            w_q         <= '0;
            h_q         <= '0;
            k_q         <= '0;
            r_q         <= '0;
            c_q         <= '0;
            ptr_q       <= '0;
            sr_q        <= '0;
            win_valid_q <= 1'b0;
            win_data_q  <= '0;
            row_q       <= '0;
            col_q       <= '0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            w_q         <= w_d;
            h_q         <= h_d;
            k_q         <= k_d;
            r_q         <= r_d;
            c_q         <= c_d;
            ptr_q       <= ptr_d;
            sr_q        <= sr_d;
            win_valid_q <= win_valid_d;
            win_data_q  <= win_data_d;
            row_q       <= row_d;
            col_q       <= col_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign win_valid_o = win_valid_q;
    assign win_data_o  = win_data_q;
    assign win_row_o   = row_q;
    assign win_col_o   = col_q;
    assign busy_o      = (state_q == StLoad) || (state_q == StDrain);
    assign done_o      = (state_q == StDone);
    assign cfg_err_o   = cfg_err_q;

endmodule

// File: tb/tb_window_streamer.sv
// Directed and randomized frames for window_streamer; every presented window is
// compared with one cut straight out of a stored image.
module tb_window_streamer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start_i;
    logic [5:0]   img_w_i, img_h_i;
    logic [15:0]  ksize_i;
    logic         in_valid_i;
    logic         in_ready_o;
    logic [15:0]  in_pixel_i;
    logic         win_valid_o;
    logic         win_ready_i;
    logic [399:0] win_data_o;
    logic [5:0]   win_row_o, win_col_o;
    logic         busy_o, done_o, cfg_err_o;

    int total = 0;
    int bad   = 0;
    logic [15:0] img [0:31][0:31];

    always #5 clk = ~clk;

    window_streamer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .img_w_i    (img_w_i),
        .img_h_i    (img_h_i),
        .ksize_i    (ksize_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .in_pixel_i (in_pixel_i),
        .win_valid_o(win_valid_o),
        .win_ready_i(win_ready_i),
        .win_data_o (win_data_o),
        .win_row_o  (win_row_o),
        .win_col_o  (win_col_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .cfg_err_o  (cfg_err_o)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_win(input string tag, input logic [399:0] obs, input logic [399:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [399:0] exp_win(input int wr, input int wc, input int k);
        logic [399:0] v;
        v = '0;
        for (int i = 0; i < k; i++)
            for (int j = 0; j < k; j++)
                v[(i*5+j)*16 +: 16] = img[wr+i][wc+j];
        return v;
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, "_in_ready"}, int'(in_ready_o), 0);
        chk({tag, "_win_valid"}, int'(win_valid_o), 0);
        chk_win({tag, "_win_data"}, win_data_o, '0);
        chk({tag, "_win_row"}, int'(win_row_o), 0);
        chk({tag, "_win_col"}, int'(win_col_o), 0);
        chk({tag, "_busy"}, int'(busy_o), 0);
        chk({tag, "_done"}, int'(done_o), 0);
        chk({tag, "_cfg_err"}, int'(cfg_err_o), 0);
    endtask

    task automatic start_frame(input int w, input int h, input int k);
        @(negedge clk);
        start_i = 1'b1;
        img_w_i = 6'(w);
        img_h_i = 6'(h);
        ksize_i = 16'(k);
        @(negedge clk);
        start_i = 1'b0;
        chk("busy_rise", int'(busy_o), 1);
    endtask

    // mode 0: in_valid/win_ready held high; mode 1: both random, plus ignored start pulses.
    task automatic run_frame(input int w, input int h, input int k, input int mode,
                             input int hold_at, input bit tput);
        int npix, nwin, nwc, pix_idx, win_idx, hold_cnt;
        int cpl_cyc, first_hs, last_hs;
        bit final_hs, done_seen, first_seen;
        npix = w * h;
        nwc  = w - k + 1;
        nwin = (h - k + 1) * nwc;
        pix_idx = 0; win_idx = 0; hold_cnt = 0;
        cpl_cyc = -1; first_hs = -1; last_hs = -1;
        final_hs = 0; done_seen = 0; first_seen = 0;
        for (int cyc = 0; cyc < 20000 && !done_seen; cyc++) begin
            @(negedge clk);
            if (final_hs) begin
                chk("done_pulse", int'(done_o), 1);
                chk("busy_at_done", int'(busy_o), 0);
                win_ready_i = 1'b0;
                done_seen = 1;
            end else begin
                in_valid_i = (pix_idx < npix) && (mode == 0 || $urandom_range(0, 3) != 0);
                in_pixel_i = (pix_idx < npix) ? img[pix_idx / w][pix_idx % w] : 16'($urandom);
                win_ready_i = (mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
                start_i = (mode == 1) && (pix_idx < npix) && ($urandom_range(0, 7) == 0);
                img_w_i = 6'($urandom);
                ksize_i = 16'($urandom);
                if (win_idx == hold_at && win_valid_o && hold_cnt < 10) begin
                    win_ready_i = 1'b0;
                    hold_cnt++;
                end
                #1;
                if (win_valid_o) begin
                    if (!first_seen) begin
                        first_seen = 1;
                        chk("first_win_latency", cyc, cpl_cyc + 1);
                    end
                    if (win_idx < nwin) begin
                        chk_win("win_data", win_data_o, exp_win(win_idx / nwc, win_idx % nwc, k));
                        chk("win_row", int'(win_row_o), win_idx / nwc);
                        chk("win_col", int'(win_col_o), win_idx % nwc);
                    end else begin
                        chk("extra_window", win_idx, nwin - 1);
                    end
                    if (!win_ready_i) chk("in_ready_while_held", int'(in_ready_o), 0);
                    if (win_ready_i) begin
                        if (first_hs < 0) first_hs = cyc;
                        last_hs = cyc;
                        win_idx++;
                        if (win_idx == nwin) final_hs = 1;
                    end
                end
                if (in_valid_i && in_ready_o) begin
                    if (cpl_cyc < 0 && pix_idx / w >= k - 1 && pix_idx % w >= k - 1)
                        cpl_cyc = cyc;
                    pix_idx++;
                end
            end
        end
        in_valid_i = 1'b0;
        start_i = 1'b0;
        chk("frame_done_seen", int'(done_seen), 1);
        chk("window_count", win_idx, nwin);
        chk("pixel_count", pix_idx, npix);
        if (tput) chk("no_gap_throughput", last_hs - first_hs, nwin - 1);
        @(negedge clk);
        chk("done_one_cycle", int'(done_o), 0);
        chk("busy_after_done", int'(busy_o), 0);
    endtask

    initial begin
        int w, h, k;
        rst_n = 1'b0; start_i = 1'b0; img_w_i = '0; img_h_i = '0; ksize_i = '0;
        in_valid_i = 1'b0; in_pixel_i = '0; win_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        rst_n = 1'b1;

        // Single 5x5 window of ramp values.
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) img[r][c] = 16'((r * 5 + c) << 10);
        start_frame(5, 5, 5);
        run_frame(5, 5, 5, 0, -1, 1'b1);

        // 7 wide x 6 high, K=3, all 1.0; then again with a 10-cycle stall at window 3.
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 7; c++) img[r][c] = 16'h0400;
        start_frame(7, 6, 3);
        run_frame(7, 6, 3, 0, -1, 1'b0);
        start_frame(7, 6, 3);
        run_frame(7, 6, 3, 0, 2, 1'b0);

        // Full-width 32x5 K=5 with random pixels: one window per cycle once rolling.
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 32; c++) img[r][c] = 16'($urandom);
        start_frame(32, 5, 5);
        run_frame(32, 5, 5, 0, -1, 1'b1);

        // Illegal configurations.
        @(negedge clk);
        start_i = 1'b1; img_w_i = 6'd5; img_h_i = 6'd5; ksize_i = 16'd4;
        @(negedge clk);
        start_i = 1'b0;
        chk("cfg_err_k4", int'(cfg_err_o), 1);
        chk("cfg_err_k4_busy", int'(busy_o), 0);
        chk("cfg_err_k4_in_ready", int'(in_ready_o), 0);
        @(negedge clk);
        chk("cfg_err_k4_pulse", int'(cfg_err_o), 0);
        start_i = 1'b1; img_w_i = 6'd2; img_h_i = 6'd5; ksize_i = 16'd3;
        @(negedge clk);
        start_i = 1'b0;
        chk("cfg_err_w2", int'(cfg_err_o), 1);
        chk("cfg_err_w2_busy", int'(busy_o), 0);
        chk("cfg_err_w2_in_ready", int'(in_ready_o), 0);
        @(negedge clk);
        chk("cfg_err_w2_pulse", int'(cfg_err_o), 0);

        // Abort a frame with reset, then run a clean checkerboard frame.
        start_frame(5, 5, 5);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            in_valid_i = 1'b1; in_pixel_i = 16'hB000; win_ready_i = 1'b1;
        end
        @(negedge clk);
        rst_n = 1'b0;
        in_valid_i = 1'b0;
        #1;
        check_idle("midframe_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_reset_in_ready", int'(in_ready_o), 0);
        chk("post_reset_busy", int'(busy_o), 0);
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) img[r][c] = ((r + c) % 2 == 1) ? 16'h0800 : 16'hB000;
        start_frame(5, 5, 5);
        run_frame(5, 5, 5, 0, -1, 1'b0);

        // Random geometry, pixels and handshake timing.
        for (int f = 0; f < 4; f++) begin
            k = ($urandom_range(0, 1) == 1) ? 5 : 3;
            w = $urandom_range(k, 32);
            h = $urandom_range(k, 8);
            for (int r = 0; r < h; r++)
                for (int c = 0; c < w; c++) img[r][c] = 16'($urandom);
            start_frame(w, h, k);
            run_frame(w, h, k, 1, -1, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
